// File: rtl/mod_74x16x_counter.sv
// Presettable synchronous counter in the 74x160/161/163 family: sync clear, sync load, ENP/ENT enables, RCO.
// Optional up/down counting with macro COUNTER_UPDOWN_EN (DN port is present in both builds).
module mod_74x16x_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_N,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             DN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_param
    $error("mod_74x16x_counter: need WIDTH>=1 and 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TC = WIDTH'(MODULUS - 1);

  logic at_tc;
  logic at_zero;
  logic [WIDTH-1:0] q_step;

  assign at_tc   = (Q == TC);
  assign at_zero = (Q == '0);

`ifdef COUNTER_UPDOWN_EN
  // Values above TC (only reachable by load) simply step by one in either direction.
  always_comb begin
    q_step = Q + 1'b1;
    if (DN)         q_step = at_zero ? TC : Q - 1'b1;
    else if (at_tc) q_step = '0;
  end

  assign RCO = ENT & (DN ? at_zero : at_tc);
`else
  logic unused_dn;
  assign unused_dn = DN;

  always_comb begin
    q_step = Q + 1'b1;
    if (at_tc) q_step = '0;
  end

  assign RCO = ENT & at_tc;
`endif

  always_ff @(posedge CLK) begin
    if (RST)             Q <= '0;
    else if (!CLR_N)     Q <= '0;
    else if (!LOAD_N)    Q <= D;
    else if (ENP && ENT) Q <= q_step;
  end

endmodule

// File: tb/tb_mod_74x16x_counter.sv
// Scoreboard bench for mod_74x16x_counter (WIDTH=4, MODULUS=10): directed cases plus random stimulus.
module tb_mod_74x16x_counter;
  localparam int W  = 4;
  localparam int M  = 10;
  localparam int TC = M - 1;

  logic         CLK = 1'b0;
  logic         RST, CLR_N, LOAD_N, ENP, ENT, DN;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         RCO;

  mod_74x16x_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .CLK(CLK), .RST(RST), .CLR_N(CLR_N), .LOAD_N(LOAD_N),
    .ENP(ENP), .ENT(ENT), .DN(DN), .D(D), .Q(Q), .RCO(RCO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    q;
    bit    rco;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   q_m   = 0;
  int   total = 0;
  int   bad   = 0;

  // Reference: next count from the family's priority rules, plain integer arithmetic.
  function automatic int next_q(int q, bit rst, bit clr_n, bit load_n, bit enp, bit ent,
                                bit dn, int d);
    if (rst || !clr_n) return 0;
    if (!load_n)       return d;
    if (!(enp && ent)) return q;
`ifdef COUNTER_UPDOWN_EN
    if (dn) return (q == 0) ? TC : q - 1;
`endif
    if (q == TC) return 0;
    return (q + 1) % (1 << W);
  endfunction

  function automatic bit exp_rco(int q, bit ent, bit dn);
`ifdef COUNTER_UPDOWN_EN
    if (dn) return ent && (q == 0);
`endif
    return ent && (q == TC);
  endfunction

  // Inputs change on the falling edge; the expected post-edge state is queued.
  task automatic drive(input bit rst, input bit clr_n, input bit load_n, input bit enp,
                       input bit ent, input bit dn, input logic [W-1:0] d, input string tag);
    exp_t e;
    @(negedge CLK);
    RST = rst; CLR_N = clr_n; LOAD_N = load_n; ENP = enp; ENT = ent; DN = dn; D = d;
    q_m   = next_q(q_m, rst, clr_n, load_n, enp, ent, dn, int'(d));
    e.q   = q_m;
    e.rco = exp_rco(q_m, ent, dn);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic cnt(input int n, input bit dn, input string tag);
    for (int i = 0; i < n; i++) drive(0, 1, 1, 1, 1, dn, 4'h0, tag);
  endtask

  task automatic load(input logic [W-1:0] d, input string tag);
    drive(0, 1, 0, 1, 1, 0, d, tag);
  endtask

  // Monitor: Q and RCO are sampled just after each rising edge, while inputs are still stable.
  always @(posedge CLK) begin
    exp_t         e;
    logic [W-1:0] eq;
    #1;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      eq = e.q[W-1:0];
      total++;
      if (Q !== eq) begin
        bad++;
        $display("FAIL %s q: got %0h expected %0h", e.tag, Q, eq);
      end
      total++;
      if (RCO !== e.rco) begin
        bad++;
        $display("FAIL %s rco: got %b expected %b (q=%0h)", e.tag, RCO, e.rco, Q);
      end
    end
  end

  initial begin
    RST = 1'b1; CLR_N = 1'b1; LOAD_N = 1'b1; ENP = 1'b1; ENT = 1'b1; DN = 1'b0; D = '0;

    drive(1, 1, 1, 1, 1, 0, 4'h0, "reset");
    cnt(12, 0, "count_up");

    load(4'h5, "load5");
    drive(0, 1, 1, 0, 1, 0, 4'h0, "hold_enp");
    drive(0, 1, 1, 1, 0, 0, 4'h0, "hold_ent");
    drive(0, 1, 1, 0, 0, 0, 4'h0, "hold_both");
    load(4'h9, "load9");
    drive(0, 1, 1, 1, 0, 0, 4'h0, "rco_ent0");
    drive(0, 1, 1, 0, 1, 0, 4'h0, "rco_enp0");

    drive(0, 1, 0, 0, 0, 0, 4'h7, "load_noen");
    drive(0, 0, 0, 1, 1, 0, 4'h3, "clr_wins");

    load(4'hC, "loadC");
    cnt(5, 0, "above_tc");

    load(4'h6, "load6");
    drive(1, 1, 0, 1, 1, 0, 4'h9, "rst_wins");
    cnt(3, 0, "resume");

    drive(0, 1, 1, 1, 1, 0, 4'bxxxx, "x_on_d");

    load(4'h2, "load2");
    cnt(4, 1, "dn_count");

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            W'($urandom_range(0, 15)), "random");
    end

    repeat (3) @(negedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
